// File: rtl/key_schedule_ctrl_pkg.sv
// rtl/key_schedule_ctrl_pkg.sv - shared types and constants for the AES-128 key schedule controller
//
// Contents:
//   ks_state_t  controller state (IDLE / EXPAND / DONE)
//   NR, NUM_RK  round count and number of stored round keys
//   rk_t        128-bit round key, row-major bytes (byte 15 = row0/col0)
//   RCON        round constant table, indexed by round counter 0..9
//   SBOX        AES forward S-box
//   rcon_of()   guarded RCON lookup (0 outside 0..9)

package key_schedule_ctrl_pkg;

   typedef enum logic [1:0] {
      IDLE   = 2'd0,
      EXPAND = 2'd1,
      DONE   = 2'd2
   } ks_state_t;

   localparam int NR     = 10;
   localparam int NUM_RK = 11;

   typedef logic [15:0][7:0] rk_t;

   localparam logic [7:0] RCON [NR] = '{
      8'h01, 8'h02, 8'h04, 8'h08, 8'h10, 8'h20, 8'h40, 8'h80, 8'h1b, 8'h36
   };

   localparam logic [7:0] SBOX [256] = '{
      8'h63, 8'h7c, 8'h77, 8'h7b, 8'hf2, 8'h6b, 8'h6f, 8'hc5, 8'h30, 8'h01, 8'h67, 8'h2b, 8'hfe, 8'hd7, 8'hab, 8'h76,
      8'hca, 8'h82, 8'hc9, 8'h7d, 8'hfa, 8'h59, 8'h47, 8'hf0, 8'had, 8'hd4, 8'ha2, 8'haf, 8'h9c, 8'ha4, 8'h72, 8'hc0,
      8'hb7, 8'hfd, 8'h93, 8'h26, 8'h36, 8'h3f, 8'hf7, 8'hcc, 8'h34, 8'ha5, 8'he5, 8'hf1, 8'h71, 8'hd8, 8'h31, 8'h15,
      8'h04, 8'hc7, 8'h23, 8'hc3, 8'h18, 8'h96, 8'h05, 8'h9a, 8'h07, 8'h12, 8'h80, 8'he2, 8'heb, 8'h27, 8'hb2, 8'h75,
      8'h09, 8'h83, 8'h2c, 8'h1a, 8'h1b, 8'h6e, 8'h5a, 8'ha0, 8'h52, 8'h3b, 8'hd6, 8'hb3, 8'h29, 8'he3, 8'h2f, 8'h84,
      8'h53, 8'hd1, 8'h00, 8'hed, 8'h20, 8'hfc, 8'hb1, 8'h5b, 8'h6a, 8'hcb, 8'hbe, 8'h39, 8'h4a, 8'h4c, 8'h58, 8'hcf,
      8'hd0, 8'hef, 8'haa, 8'hfb, 8'h43, 8'h4d, 8'h33, 8'h85, 8'h45, 8'hf9, 8'h02, 8'h7f, 8'h50, 8'h3c, 8'h9f, 8'ha8,
      8'h51, 8'ha3, 8'h40, 8'h8f, 8'h92, 8'h9d, 8'h38, 8'hf5, 8'hbc, 8'hb6, 8'hda, 8'h21, 8'h10, 8'hff, 8'hf3, 8'hd2,
      8'hcd, 8'h0c, 8'h13, 8'hec, 8'h5f, 8'h97, 8'h44, 8'h17, 8'hc4, 8'ha7, 8'h7e, 8'h3d, 8'h64, 8'h5d, 8'h19, 8'h73,
      8'h60, 8'h81, 8'h4f, 8'hdc, 8'h22, 8'h2a, 8'h90, 8'h88, 8'h46, 8'hee, 8'hb8, 8'h14, 8'hde, 8'h5e, 8'h0b, 8'hdb,
      8'he0, 8'h32, 8'h3a, 8'h0a, 8'h49, 8'h06, 8'h24, 8'h5c, 8'hc2, 8'hd3, 8'hac, 8'h62, 8'h91, 8'h95, 8'he4, 8'h79,
      8'he7, 8'hc8, 8'h37, 8'h6d, 8'h8d, 8'hd5, 8'h4e, 8'ha9, 8'h6c, 8'h56, 8'hf4, 8'hea, 8'h65, 8'h7a, 8'hae, 8'h08,
      8'hba, 8'h78, 8'h25, 8'h2e, 8'h1c, 8'ha6, 8'hb4, 8'hc6, 8'he8, 8'hdd, 8'h74, 8'h1f, 8'h4b, 8'hbd, 8'h8b, 8'h8a,
      8'h70, 8'h3e, 8'hb5, 8'h66, 8'h48, 8'h03, 8'hf6, 8'h0e, 8'h61, 8'h35, 8'h57, 8'hb9, 8'h86, 8'hc1, 8'h1d, 8'h9e,
      8'he1, 8'hf8, 8'h98, 8'h11, 8'h69, 8'hd9, 8'h8e, 8'h94, 8'h9b, 8'h1e, 8'h87, 8'he9, 8'hce, 8'h55, 8'h28, 8'hdf,
      8'h8c, 8'ha1, 8'h89, 8'h0d, 8'hbf, 8'he6, 8'h42, 8'h68, 8'h41, 8'h99, 8'h2d, 8'h0f, 8'hb0, 8'h54, 8'hbb, 8'h16
   };

   function automatic logic [7:0] rcon_of(input logic [3:0] rc);
      logic [7:0] r;
      r = 8'h00;
      if (rc < 4'(NR)) r = RCON[rc];
      return r;
   endfunction

endpackage

// File: rtl/key_schedule_ctrl_keyexpand.sv
// rtl/key_schedule_ctrl_keyexpand.sv - one-round combinational AES-128 key expander
//
// Ports:
//   rk_cur  in   current round key, row-major bytes (byte 15 = row0/col0)
//   rc      in   round counter 0..9, selects the round constant
//   rk_nxt  out  next round key, same byte layout

module keyexpand
   import key_schedule_ctrl_pkg::*;
(
   input  logic [15:0][7:0] rk_cur,
   input  logic [3:0]       rc,
   output logic [15:0][7:0] rk_nxt
);

   // Columns packed as {row0,row1,row2,row3}; column c lives at bytes 15-c, 11-c, 7-c, 3-c.
   logic [31:0] c0, c1, c2, c3;
   logic [31:0] n0, n1, n2, n3;
   logic [31:0] tmp;

   always_comb begin
      c0 = {rk_cur[15], rk_cur[11], rk_cur[7], rk_cur[3]};
      c1 = {rk_cur[14], rk_cur[10], rk_cur[6], rk_cur[2]};
      c2 = {rk_cur[13], rk_cur[9],  rk_cur[5], rk_cur[1]};
      c3 = {rk_cur[12], rk_cur[8],  rk_cur[4], rk_cur[0]};

      // RotWord then SubWord on the last column; rcon lands on row 0.
      tmp = {SBOX[c3[23:16]] ^ rcon_of(rc), SBOX[c3[15:8]], SBOX[c3[7:0]], SBOX[c3[31:24]]};

      n0 = c0 ^ tmp;
      n1 = c1 ^ n0;
      n2 = c2 ^ n1;
      n3 = c3 ^ n2;

      rk_nxt = {n0[31:24], n1[31:24], n2[31:24], n3[31:24],
                n0[23:16], n1[23:16], n2[23:16], n3[23:16],
                n0[15:8],  n1[15:8],  n2[15:8],  n3[15:8],
                n0[7:0],   n1[7:0],   n2[7:0],   n3[7:0]};
   end

endmodule

// File: rtl/key_schedule_ctrl.sv
// rtl/key_schedule_ctrl.sv - sequential AES-128 key schedule controller with indexed round-key read port
//
// Accepts a cipher key over key_valid/key_ready, expands one round per cycle into
// an 11-entry round-key store, and serves stored keys through a registered read port.
// Optional build macro KEYSCHED_ZEROIZE_EN adds a synchronous key-material clear.
//
// Ports:
//   clk          in   clock, rising edge
//   rst_n        in   asynchronous active-low reset
//   key_in       in   cipher key, row-major bytes (byte 15 = row0/col0)
//   key_valid    in   key_in valid
//   key_ready    out  key can be accepted (IDLE or DONE)
//   busy         out  expansion in progress
//   sched_valid  out  all 11 round keys match the last accepted key
//   zeroize      in   (KEYSCHED_ZEROIZE_EN only) clear all key material, return to IDLE
//   rd_idx       in   round-key index 0..10
//   rd_key       out  round key for rd_idx sampled on the previous edge; 0 if index > 10

module key_schedule_ctrl
   import key_schedule_ctrl_pkg::*;
(
   input  logic             clk,
   input  logic             rst_n,
   input  logic [15:0][7:0] key_in,
   input  logic             key_valid,
   output logic             key_ready,
   output logic             busy,
   output logic             sched_valid,
`ifdef KEYSCHED_ZEROIZE_EN
   input  logic             zeroize,
`endif
   input  logic [3:0]       rd_idx,
   output logic [15:0][7:0] rd_key
);

   ks_state_t        state, state_nxt;
   logic [3:0]       cnt;
   logic             accept;
   logic [15:0][7:0] rk [NUM_RK];
   logic [15:0][7:0] rk_nxt;

   keyexpand u_keyexpand (
      .rk_cur (rk[cnt]),
      .rc     (cnt),
      .rk_nxt (rk_nxt)
   );

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state <= IDLE;
      end else begin
`ifdef KEYSCHED_ZEROIZE_EN
         if (zeroize) state <= IDLE;
         else
`endif
         state <= state_nxt;
      end
   end

   always_comb begin
      state_nxt   = state;
      key_ready   = 1'b0;
      busy        = 1'b0;
      sched_valid = 1'b0;
      accept      = 1'b0;
      case (state)
         IDLE: begin
            key_ready = 1'b1;
            if (key_valid) begin
               accept    = 1'b1;
               state_nxt = EXPAND;
            end
         end
         EXPAND: begin
            busy = 1'b1;
            if (cnt == 4'(NR - 1)) state_nxt = DONE;
         end
         DONE: begin
            key_ready   = 1'b1;
            sched_valid = 1'b1;
            if (key_valid) begin
               accept    = 1'b1;
               state_nxt = EXPAND;
            end
         end
         default: state_nxt = IDLE;
      endcase
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         cnt    <= '0;
         rd_key <= '0;
         for (int i = 0; i < NUM_RK; i++) rk[i] <= '0;
      end else begin
`ifdef KEYSCHED_ZEROIZE_EN
         if (zeroize) begin
            cnt    <= '0;
            rd_key <= '0;
            for (int i = 0; i < NUM_RK; i++) rk[i] <= '0;
         end else
`endif
         begin
            // Read sees storage before this edge's write, so reads during EXPAND may be stale.
            rd_key <= (rd_idx <= 4'(NR)) ? rk[rd_idx] : '0;
            if (accept) begin
               rk[0] <= key_in;
               cnt   <= '0;
            end else if (state == EXPAND) begin
               rk[cnt + 4'd1] <= rk_nxt;
               cnt            <= (cnt == 4'(NR - 1)) ? 4'd0 : cnt + 4'd1;
            end
         end
      end
   end

endmodule

// File: tb/tb_key_schedule_ctrl.sv
// tb/tb_key_schedule_ctrl.sv - scoreboard bench for key_schedule_ctrl against a word-level AES-128 key schedule model

module tb_key_schedule_ctrl;

   logic             clk = 1'b0;
   logic             rst_n = 1'b0;
   logic [15:0][7:0] key_in = '0;
   logic             key_valid = 1'b0;
   logic             key_ready, busy, sched_valid;
   logic             zeroize = 1'b0;
   logic [3:0]       rd_idx = '0;
   logic [15:0][7:0] rd_key;

   always #5 clk = ~clk;

   key_schedule_ctrl dut (
      .clk         (clk),
      .rst_n       (rst_n),
      .key_in      (key_in),
      .key_valid   (key_valid),
      .key_ready   (key_ready),
      .busy        (busy),
      .sched_valid (sched_valid),
`ifdef KEYSCHED_ZEROIZE_EN
      .zeroize     (zeroize),
`endif
      .rd_idx      (rd_idx),
      .rd_key      (rd_key)
   );

   localparam logic [127:0] FIPS_KEY = 128'h2b28ab09_7eaef7cf_15d2154f_16a6883c;
   localparam logic [127:0] FIPS_RK1 = 128'ha088232a_fa54a36c_fe2c3976_17b13905;
   localparam logic [127:0] FIPS_RK10 = 128'hd0c9e1b6_14ee3f63_f9250c0c_a889c8a6;

   int checks = 0;
   int errors = 0;

   task automatic check(input string name, input logic [127:0] act, input logic [127:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %h expected %h", name, act, exp);
      end
   endtask

   // S-box derived from GF(2^8) inversion plus the affine map.
   logic [7:0] sb [256];

   function automatic logic [7:0] gf_mul(input logic [7:0] a, input logic [7:0] b);
      logic [7:0] p = 0;
      for (int i = 0; i < 8; i++) begin
         if (b[0]) p = p ^ a;
         a = {a[6:0], 1'b0} ^ (a[7] ? 8'h1b : 8'h00);
         b = b >> 1;
      end
      return p;
   endfunction

   function automatic logic [7:0] rotl8(input logic [7:0] v, input int n);
      return (v << n) | (v >> (8 - n));
   endfunction

   task automatic build_sbox();
      for (int a = 0; a < 256; a++) begin
         logic [7:0] inv = 0;
         for (int x = 1; x < 256; x++)
            if (gf_mul(8'(a), 8'(x)) == 8'h01) inv = 8'(x);
         sb[a] = inv ^ rotl8(inv, 1) ^ rotl8(inv, 2) ^ rotl8(inv, 3) ^ rotl8(inv, 4) ^ 8'h63;
      end
   endtask

   // Reference model: full schedule as FIPS-197 words, then relaid into row-major byte order.
   logic [127:0] m_rk [11];
   int           m_left = 0;
   bit           m_sched = 0;

   task automatic model_expand(input logic [127:0] k);
      logic [31:0] w [44];
      logic [31:0] t;
      logic [7:0]  rc;
      for (int c = 0; c < 4; c++)
         w[c] = {k[8*(15-c) +: 8], k[8*(11-c) +: 8], k[8*(7-c) +: 8], k[8*(3-c) +: 8]};
      rc = 8'h01;
      for (int i = 4; i < 44; i++) begin
         t = w[i-1];
         if (i % 4 == 0) begin
            t = {t[23:0], t[31:24]};
            t = {sb[t[31:24]], sb[t[23:16]], sb[t[15:8]], sb[t[7:0]]} ^ {rc, 24'h0};
            rc = {rc[6:0], 1'b0} ^ (rc[7] ? 8'h1b : 8'h00);
         end
         w[i] = w[i-4] ^ t;
      end
      for (int r = 0; r < 11; r++)
         for (int c = 0; c < 4; c++)
            for (int row = 0; row < 4; row++)
               m_rk[r][8*(15-4*row-c) +: 8] = w[4*r+c][31-8*row -: 8];
   endtask

   always @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         m_left = 0;
         m_sched = 0;
         for (int i = 0; i < 11; i++) m_rk[i] = '0;
      end else if (zeroize) begin
         m_left = 0;
         m_sched = 0;
         for (int i = 0; i < 11; i++) m_rk[i] = '0;
      end else if (m_left > 0) begin
         m_left--;
         if (m_left == 0) m_sched = 1;
      end else if (key_valid) begin
         m_left = 10;
         m_sched = 0;
         model_expand(key_in);
      end
   end

   function automatic logic [127:0] exp_rd(input int idx);
      return (idx <= 10) ? m_rk[idx] : 128'h0;
   endfunction

   // Scoreboard: reads push expectations; monitor pops one cycle after the sampling edge.
   logic [127:0] exp_q [$];
   logic         rd_chk = 1'b0;

   initial begin
      forever begin
         bit chk;
         @(posedge clk);
         chk = rd_chk;
         #1;
         if (chk) begin
            if (exp_q.size() == 0) check("rd_queue_empty", 128'h1, 128'h0);
            else check("rd_key", rd_key, exp_q.pop_front());
         end
         check("key_ready", 128'(key_ready), 128'(m_left == 0));
         check("busy", 128'(busy), 128'(m_left > 0));
         check("sched_valid", 128'(sched_valid), 128'(m_sched));
      end
   end

   task automatic rd(input int idx, input logic [127:0] e);
      rd_idx = 4'(idx);
      rd_chk = 1'b1;
      exp_q.push_back(e);
      @(negedge clk);
      rd_chk = 1'b0;
   endtask

   task automatic send_key(input logic [127:0] k);
      key_in = k;
      key_valid = 1'b1;
      @(negedge clk);
      key_valid = 1'b0;
   endtask

   task automatic wait_sched();
      for (int i = 0; i < 20 && !sched_valid; i++) @(negedge clk);
      check("sched_timeout", 128'(sched_valid), 128'h1);
   endtask

   function automatic logic [127:0] rand128();
      return {$urandom, $urandom, $urandom, $urandom};
   endfunction

   initial begin
      for (int i = 0; i < 11; i++) m_rk[i] = '0;
      build_sbox();
      repeat (3) @(negedge clk);
      check("reset_rd_key", rd_key, 128'h0);
      check("reset_key_ready", 128'(key_ready), 128'h1);
      rst_n = 1'b1;
      @(negedge clk);

      // FIPS key, with a competing key pulsed mid-expansion.
      send_key(FIPS_KEY);
      @(negedge clk);
      send_key(rand128());
      key_in = rand128();
      wait_sched();
      rd(10, FIPS_RK10);
      rd(1, FIPS_RK1);
      rd(0, FIPS_KEY);
      rd(11, 128'h0);
      rd(15, 128'h0);

      // Reset at cnt=5 aborts expansion.
      send_key(rand128());
      repeat (5) @(negedge clk);
      #1 rst_n = 1'b0;
      #1;
      check("abort_key_ready", 128'(key_ready), 128'h1);
      check("abort_busy", 128'(busy), 128'h0);
      check("abort_sched_valid", 128'(sched_valid), 128'h0);
      check("abort_rd_key", rd_key, 128'h0);
      @(negedge clk);
      rst_n = 1'b1;
      @(negedge clk);
      send_key(FIPS_KEY);
      wait_sched();
      for (int i = 0; i < 11; i++) rd(i, exp_rd(i));
      rd(10, FIPS_RK10);

      // Random keys accepted straight from DONE while reading the previous final key.
      for (int n = 0; n < 6; n++) begin
         key_in = rand128();
         key_valid = 1'b1;
         rd_idx = 4'd10;
         rd_chk = 1'b1;
         exp_q.push_back(exp_rd(10));
         @(negedge clk);
         key_valid = 1'b0;
         rd_chk = 1'b0;
         wait_sched();
         rd(10, exp_rd(10));
         for (int i = 0; i < 16; i++) rd(i, exp_rd(i));
         rd(0, key_in);
         rd($urandom_range(11, 15), 128'h0);
      end

`ifdef KEYSCHED_ZEROIZE_EN
      zeroize = 1'b1;
      key_in = rand128();
      key_valid = 1'b1;
      @(negedge clk);
      zeroize = 1'b0;
      key_valid = 1'b0;
      check("zeroize_sched_valid", 128'(sched_valid), 128'h0);
      check("zeroize_busy", 128'(busy), 128'h0);
      for (int i = 0; i < 11; i++) rd(i, 128'h0);
`endif

      repeat (3) @(negedge clk);
      check("scoreboard_drained", 128'(exp_q.size()), 128'h0);
      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
